// File: rtl/jk_bank_arbiter.sv
// Bank of N_BITS JK bits shared by four requesters through a 3-cycle grant/apply/ack handshake.
// Define JK_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest); default is round-robin.
module jk_bank_arbiter #(
  parameter int N_BITS = 8,
  localparam int AW = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bank_set,
  input  logic              bank_clr,
  input  logic [3:0]        req,
  input  logic [3:0]        cmd_j,
  input  logic [3:0]        cmd_k,
  input  logic [4*AW-1:0]   cmd_addr,
  output logic [N_BITS-1:0] q,
  output logic [3:0]        gnt,
  output logic [3:0]        ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   bank_q, bank_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          ack_q, ack_d;
  logic [1:0]          win_q, win_d;
  logic                busy_q, busy_d;
  logic [1:0]          win_s;
  logic                bulk_s;
  logic [AW-1:0]       addr_s;
  logic                cmd_j_s, cmd_k_s;
`ifndef JK_ARB_FIXED_PRIO_EN
  logic [1:0]          ptr_q, ptr_d;
`endif

  // First requester found scanning upward from start, wrapping 3 -> 0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

`ifdef JK_ARB_FIXED_PRIO_EN
  assign win_s = pick(req, 2'd0);
`else
  assign win_s = pick(req, ptr_q);
`endif

  assign bulk_s  = bank_set | bank_clr;
  assign addr_s  = cmd_addr[win_q*AW +: AW];
  assign cmd_j_s = cmd_j[win_q];
  assign cmd_k_s = cmd_k[win_q];

  // Next-state, bank update and handshake outputs.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    gnt_d   = gnt_q;
    ack_d   = 4'b0000;
    win_d   = win_q;
`ifndef JK_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif

    if (bank_set && bank_clr) begin
      bank_d = ~bank_q;
    end else if (bank_clr) begin
      bank_d = {N_BITS{1'b0}};
    end else if (bank_set) begin
      bank_d = {N_BITS{1'b1}};
    end else begin
      bank_d = bank_q;
    end

    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = win_s;
          gnt_d   = 4'b0001 << win_s;
          state_d = APPLY;
        end else begin
          gnt_d   = 4'b0000;
        end
      end
      APPLY: begin
        // A bulk op stalls the grant; the command lands on the first quiet edge.
        if (bulk_s) begin
          state_d = APPLY;
        end else if (req[win_q]) begin
          case ({cmd_j_s, cmd_k_s})
            2'b01:   bank_d[addr_s] = 1'b0;
            2'b10:   bank_d[addr_s] = 1'b1;
            2'b11:   bank_d[addr_s] = ~bank_q[addr_s];
            default: bank_d[addr_s] = bank_q[addr_s];
          endcase
          ack_d   = gnt_q;
          state_d = ACK;
`ifndef JK_ARB_FIXED_PRIO_EN
          ptr_d   = win_q + 2'd1;
`endif
        end else begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end
      end
      ACK: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State registers, updated on the falling clock edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bank_q  <= {N_BITS{1'b0}};
      gnt_q   <= 4'b0000;
      ack_q   <= 4'b0000;
      win_q   <= 2'd0;
      busy_q  <= 1'b0;
`ifndef JK_ARB_FIXED_PRIO_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
`ifndef JK_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign q    = bank_q;
  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: expected acks are queued at issue time and matched by a monitor.
module tb_jk_bank_arbiter;

  logic        clk;
  logic        reset;
  logic        bank_set, bank_clr;
  logic [3:0]  req, cmd_j, cmd_k;
  logic [11:0] cmd_addr;
  logic [7:0]  q;
  logic [3:0]  gnt, ack;
  logic        busy;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] exp_g [5];
  logic [7:0] exp_qv[5];

  jk_bank_arbiter #(.N_BITS(8)) dut (
    .clk(clk), .reset(reset), .bank_set(bank_set), .bank_clr(bank_clr),
    .req(req), .cmd_j(cmd_j), .cmd_k(cmd_k), .cmd_addr(cmd_addr),
    .q(q), .gnt(gnt), .ack(ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // DUT registers change on negedge; the monitor samples on posedge.
  always @(posedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1 && ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack=%b q=0x%h expected no ack", ack, q);
      end else begin
        e = sb.pop_front();
        check("ack_onehot", 32'(ack), 32'(e.ack));
        check("ack_q", 32'(q), 32'(e.q));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_q"}, 32'(q), 32'h0);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    reset = 1'b0; req = 4'b0000; bank_set = 1'b0; bank_clr = 1'b0;
    #1 check_reset(tag);
    @(posedge clk);
    reset = 1'b1;
  endtask

  task automatic bulk(input logic s, input logic c, input int n);
    @(posedge clk);
    bank_set = s; bank_clr = c;
    repeat (n) @(posedge clk);
    bank_set = 1'b0; bank_clr = 1'b0;
  endtask

  task automatic do_op(input int idx, input logic j, input logic k,
                       input logic [2:0] a, input logic [7:0] exp_q);
    exp_t       e;
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    @(posedge clk);
    req = oh; cmd_j[idx] = j; cmd_k[idx] = k; cmd_addr[idx*3 +: 3] = a;
    e.ack = oh; e.q = exp_q;
    sb.push_back(e);
    @(posedge clk);
    check("op_gnt", 32'(gnt), 32'(oh));
    check("op_busy", 32'(busy), 32'h1);
    @(posedge clk);
    req = 4'b0000;
    @(posedge clk);
    check("op_idle_busy", 32'(busy), 32'h0);
    check("op_idle_gnt", 32'(gnt), 32'h0);
  endtask

  initial begin
    exp_t e;
`ifdef JK_ARB_FIXED_PRIO_EN
    exp_g  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_qv = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
`else
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_qv = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
`endif
    reset = 1'b0; bank_set = 1'b0; bank_clr = 1'b0;
    req = 4'b0000; cmd_j = 4'b0000; cmd_k = 4'b0000; cmd_addr = 12'h000;
    #1 check_reset("por");
    @(posedge clk);
    reset = 1'b1;

    // Single set of bit 5 by requester 0.
    do_op(0, 1'b1, 1'b0, 3'd5, 8'h20);

    // All four requesters toggling their own bit.
    pulse_reset("rst_a");
    @(posedge clk);
    req = 4'b1111; cmd_j = 4'b1111; cmd_k = 4'b1111;
    cmd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int n = 0; n < 5; n++) begin
      e.ack = exp_g[n]; e.q = exp_qv[n];
      sb.push_back(e);
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      check("rr_gnt", 32'(gnt), 32'(exp_g[n]));
      @(posedge clk);
      if (n == 4) req = 4'b0000;
      @(posedge clk);
    end
    check("rr_end_busy", 32'(busy), 32'h0);

    // Bulk set for two edges stalls requester 2 in APPLY.
    bulk(1'b0, 1'b1, 1);
    check("clr_q", 32'(q), 32'h00);
    @(posedge clk);
    req = 4'b0100; cmd_j = 4'b0000; cmd_k = 4'b0100; cmd_addr = 12'h000;
    e.ack = 4'b0100; e.q = 8'hFE;
    sb.push_back(e);
    @(posedge clk);
    check("stall_gnt0", 32'(gnt), 32'h4);
    bank_set = 1'b1;
    @(posedge clk);
    check("stall_q1", 32'(q), 32'hFF);
    check("stall_gnt1", 32'(gnt), 32'h4);
    check("stall_busy1", 32'(busy), 32'h1);
    @(posedge clk);
    check("stall_q2", 32'(q), 32'hFF);
    check("stall_gnt2", 32'(gnt), 32'h4);
    bank_set = 1'b0;
    @(posedge clk);
    check("stall_q3", 32'(q), 32'hFE);
    req = 4'b0000;
    @(posedge clk);
    check("stall_busy_end", 32'(busy), 32'h0);

    // Build 0xA5 one requester at a time, then bulk toggle.
    bulk(1'b0, 1'b1, 1);
    do_op(3, 1'b1, 1'b0, 3'd7, 8'h80);
    do_op(0, 1'b1, 1'b0, 3'd0, 8'h81);
    do_op(1, 1'b1, 1'b0, 3'd2, 8'h85);
    do_op(2, 1'b1, 1'b0, 3'd5, 8'hA5);
    check("a5_q", 32'(q), 32'hA5);
    bulk(1'b1, 1'b1, 1);
    check("toggle_q", 32'(q), 32'h5A);
    check("toggle_busy", 32'(busy), 32'h0);
    check("toggle_gnt", 32'(gnt), 32'h0);

    // Abandoned grant leaves bank and pointer untouched.
    pulse_reset("rst_b");
    @(posedge clk);
    req = 4'b0010; cmd_j = 4'b0010; cmd_k = 4'b0000; cmd_addr = {3'd0, 3'd0, 3'd4, 3'd0};
    @(posedge clk);
    check("abn_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    @(posedge clk);
    check("abn_gnt_clr", 32'(gnt), 32'h0);
    check("abn_busy", 32'(busy), 32'h0);
    check("abn_q", 32'(q), 32'h00);
    req = 4'b0111; cmd_j = 4'b0111; cmd_k = 4'b0000;
    cmd_addr = {3'd0, 3'd6, 3'd4, 3'd1};
    e.ack = 4'b0001; e.q = 8'h02;
    sb.push_back(e);
    @(posedge clk);
    check("abn_next_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    req = 4'b0000;
    @(posedge clk);
    check("abn_next_q", 32'(q), 32'h02);
    check("abn_next_busy", 32'(busy), 32'h0);

    // Reset pulse mid-APPLY discards the command.
    @(posedge clk);
    req = 4'b0001; cmd_j = 4'b0001; cmd_k = 4'b0000; cmd_addr = 12'h003;
    @(posedge clk);
    check("mid_gnt", 32'(gnt), 32'h1);
    reset = 1'b0; req = 4'b0000;
    #1 check_reset("mid_rst");
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    check("mid_q_after", 32'(q), 32'h00);
    check("mid_busy_after", 32'(busy), 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 SHALL have parameter: N_BITS, 8, number of JK bits in the bank; power of two, 2..16; AW = log2(N_BITS).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the falling edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: bank_set  input  1  bulk set of all bank bits.
REQ-005 SHALL have port: bank_clr  input  1  bulk clear of all bank bits.
REQ-006 SHALL have port: req  input  4  per-requester request, level.
REQ-007 SHALL have port: cmd_j  input  4  per-requester J value.
REQ-008 SHALL have port: cmd_k  input  4  per-requester K value.
REQ-009 SHALL have port: cmd_addr  input  4*AW  per-requester target bit index; requester i at [i*AW +: AW].
REQ-010 SHALL have port: q  output  N_BITS  bank state, registered.
REQ-011 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-012 SHALL have port: ack  output  4  one-hot, one-cycle completion pulse, registered.
REQ-013 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY and ACK.
REQ-015 IDLE: if any req is high at a falling edge, SHALL select a winner, assert gnt[winner] and enter APPLY; otherwise SHALL stay in IDLE with gnt = 0.
REQ-016 Winner selection SHALL be round-robin: search starts at the pointer and wraps 3 -> 0.
REQ-017 The pointer SHALL be set to (winner+1) mod 4 on entry to ACK.
REQ-018 APPLY, with req[winner] high and no bulk op: bit q[cmd_addr[winner]] SHALL update per {J,K}: 00 hold, 01 clear, 10 set, 11 toggle. The FSM SHALL then enter ACK.
REQ-019 Command fields SHALL be sampled at the APPLY edge only; a requester SHALL hold them stable while its gnt is high.
REQ-020 APPLY, with req[winner] low: the command SHALL be abandoned. The FSM SHALL return to IDLE with no bank update, no ack and no pointer change.
REQ-021 ACK: ack[winner] SHALL be high for exactly one cycle. gnt SHALL clear at the next edge and the FSM SHALL return to IDLE. Each operation therefore takes 3 cycles.
REQ-022 Bulk ops SHALL be evaluated at every edge in any state and SHALL take priority over requester commands.
REQ-023 Bulk op encoding: bank_set & bank_clr SHALL toggle all bits; bank_clr alone SHALL clear all bits; bank_set alone SHALL set all bits.
REQ-024 A bulk op in APPLY SHALL stall the FSM in APPLY, holding gnt; the requester command SHALL be applied at the first edge with no bulk op.
REQ-025 Addresses SHALL always be in range because N_BITS = 2^AW.
REQ-026 A requester re-asserting req after its ack SHALL lose to any other pending requester.

Reset
REQ-027 reset low SHALL immediately force q = 0, gnt = 0, ack = 0, busy = 0, state IDLE and pointer 0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard the pending command with no ack.
REQ-029 After reset deasserts, the first arbitration SHALL occur at the next falling edge.

Configuration
REQ-030 SHALL support macro JK_ARB_FIXED_PRIO_EN.
REQ-031 When JK_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest) and the pointer SHALL be absent.
REQ-032 When JK_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-016/017.
REQ-033 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-034 Reset, then req=0001, cmd_j[0]=1, cmd_k[0]=0, addr0=5 -> gnt=0001 at edge 1; q=0x20 and ack=0001 at edge 2; IDLE and busy=0 at edge 3.
REQ-035 req=1111 held, all commands toggle with addr_i=i -> grants in order 0,1,2,3,0; q sequence 0x01, 0x03, 0x07, 0x0F, 0x0E. Under JK_ARB_FIXED_PRIO_EN -> requester 0 granted every time.
REQ-036 q=0x00, requester 2 granted, bank_set=1 during APPLY for 2 cycles with cmd 01 addr 0 -> FSM stays in APPLY with gnt=0100; q=0xFF, then 0xFE; ack[2] follows.
REQ-037 bank_set=bank_clr=1 for one edge with q=0xA5 -> q=0x5A; FSM state unaffected.
REQ-038 Requester 1 granted, req[1] drops before APPLY edge -> no q change, no ack, next arbitration still starts at pointer 0 for requester 0.
REQ-039 reset pulsed low mid-APPLY between edges -> q, gnt, ack, busy go to 0 immediately; no ack after release.
